// File: rtl/conv2d_engine_if.sv
// Handshake and pixel-stream bundle for conv2d_engine.
// The master side drives the run controls; the slave side is the engine itself.
interface conv2d_engine_if #(
  parameter int IDX_W = 3
);
  logic             en;
  logic             start;
  logic             busy;
  logic             done;
  logic             pix_valid;
  logic [IDX_W-1:0] pix_row;
  logic [IDX_W-1:0] pix_col;
  logic [31:0]      pix_data;

  modport master (
    output en, start,
    input  busy, done, pix_valid, pix_row, pix_col, pix_data
  );

  modport slave (
    input  en, start,
    output busy, done, pix_valid, pix_row, pix_col, pix_data
  );
endinterface

// File: rtl/conv2d_engine.sv
// Stride-1 valid 2D convolution using one multiply-accumulate per enabled cycle.
// The input map and kernel are snapshotted at start; results stream out row-major.
module conv2d_engine #(
  parameter  int IN_SIZE  = 9,
  parameter  int K        = 3,
  localparam int OUT_SIZE = IN_SIZE - K + 1,
  localparam int IDX_W    = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1
) (
  input  logic               clk,
  input  logic               reset_n,
  conv2d_engine_if.slave     bus,
  input  logic [31:0]        in_map  [IN_SIZE][IN_SIZE],
  input  logic [31:0]        weights [K][K],
  output logic [31:0]        out_map [OUT_SIZE][OUT_SIZE]
);

  localparam int KW = (K > 1) ? $clog2(K) : 1;
  localparam int MW = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MAC,
    S_WRITE,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_nextState;

  logic [31:0]      r_snapMap [IN_SIZE][IN_SIZE];
  logic [31:0]      r_snapW   [K][K];
  logic [31:0]      r_acc;
  logic [IDX_W-1:0] r_row;
  logic [IDX_W-1:0] r_col;
  logic [KW-1:0]    r_ki;
  logic [KW-1:0]    r_kj;
  logic             r_pixValid;
  logic [IDX_W-1:0] r_pixRow;
  logic [IDX_W-1:0] r_pixCol;
  logic [31:0]      r_pixData;

  logic             w_lastTap;
  logic             w_lastCol;
  logic             w_lastPix;
  logic [MW-1:0]    w_mapRow;
  logic [MW-1:0]    w_mapCol;
  logic [31:0]      w_prod;

  assign w_lastTap = (r_ki == KW'(K - 1)) && (r_kj == KW'(K - 1));
  assign w_lastCol = (r_col == IDX_W'(OUT_SIZE - 1));
  assign w_lastPix = w_lastCol && (r_row == IDX_W'(OUT_SIZE - 1));
  assign w_mapRow  = MW'(r_row) + MW'(r_ki);
  assign w_mapCol  = MW'(r_col) + MW'(r_kj);
  // Low 32 bits of a signed product equal those of the unsigned product.
  assign w_prod    = r_snapMap[w_mapRow][w_mapCol] * r_snapW[r_ki][r_kj];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else if (bus.en) begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      S_IDLE:  if (bus.start) w_nextState = S_MAC;
      S_MAC:   if (w_lastTap) w_nextState = S_WRITE;
      S_WRITE: w_nextState = w_lastPix ? S_DONE : S_MAC;
      S_DONE:  w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_snapMap  <= '{default: '0};
      r_snapW    <= '{default: '0};
      out_map    <= '{default: '0};
      r_acc      <= '0;
      r_row      <= '0;
      r_col      <= '0;
      r_ki       <= '0;
      r_kj       <= '0;
      r_pixValid <= 1'b0;
      r_pixRow   <= '0;
      r_pixCol   <= '0;
      r_pixData  <= '0;
    end else if (bus.en) begin
      r_pixValid <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_snapMap <= in_map;
            r_snapW   <= weights;
            r_row     <= '0;
            r_col     <= '0;
            r_ki      <= '0;
            r_kj      <= '0;
            r_acc     <= '0;
          end
        end
        S_MAC: begin
          r_acc <= r_acc + w_prod;
          if (r_kj == KW'(K - 1)) begin
            r_kj <= '0;
            r_ki <= (r_ki == KW'(K - 1)) ? '0 : r_ki + 1'b1;
          end else begin
            r_kj <= r_kj + 1'b1;
          end
        end
        S_WRITE: begin
          out_map[r_row][r_col] <= r_acc;
          r_pixValid <= 1'b1;
          r_pixRow   <= r_row;
          r_pixCol   <= r_col;
          r_pixData  <= r_acc;
          r_acc      <= '0;
          // Row index wraps after the final pixel so it never leaves the array.
          if (w_lastCol) begin
            r_col <= '0;
            r_row <= w_lastPix ? '0 : r_row + 1'b1;
          end else begin
            r_col <= r_col + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = (r_state != S_IDLE);
  assign bus.done      = (r_state == S_DONE);
  assign bus.pix_valid = r_pixValid;
  assign bus.pix_row   = r_pixRow;
  assign bus.pix_col   = r_pixCol;
  assign bus.pix_data  = r_pixData;

endmodule
